// File: rtl/io_entrada_responder.sv
// Device-side responder for the CPU IN instruction: synchronises and debounces the board
// button, waits for an operator-confirmed switch value and returns it with a valid pulse.
// Optional feature: define IO_TIMEOUT_EN to bound the wait for a press to TIMEOUT_CYCLES.
module io_entrada_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              botaoIN,
    input  logic [3:0]        entradaDeDados,
    input  logic              req_in,
    output logic [DATA_W-1:0] dado_lido,
    output logic              dado_valido,
    output logic              ocupado,
    output logic              ledin,
    output logic              timeout
);

    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitPress,
        StDone,
        StWaitReqLow
    } state_e;

    state_e            state_q, state_d;
    logic              btn_s1_q, btn_s2_q;
    logic [3:0]        sw_s1_q, sw_s2_q;
    logic [DbW-1:0]    db_cnt_q;
    logic              btn_db_q, btn_db_prev_q;
    logic              press_q;
    logic [DATA_W-1:0] dado_lido_q;
    logic              cap_press, cap_timeout;
    logic              timeout_hit;

    // Two-flop synchronisers for the asynchronous button and switches
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            sw_s1_q  <= 4'h0;
            sw_s2_q  <= 4'h0;
        end else begin
            btn_s1_q <= botaoIN;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= entradaDeDados;
            sw_s2_q  <= sw_s1_q;
        end
    end

    // Debounce: btn_db follows the synced button only after DEBOUNCE_CYCLES differing cycles;
    // press is a registered rising-edge pulse of the debounced level
    always_ff @(posedge clock) begin
        if (reset) begin
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            press_q       <= 1'b0;
        end else begin
            if (btn_s2_q != btn_db_q) begin
                if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_db_q <= ~btn_db_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
            btn_db_prev_q <= btn_db_q;
            press_q       <= btn_db_q & ~btn_db_prev_q;
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam int unsigned TmW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TmW-1:0] wait_cnt_q;
    logic           timeout_q;

    assign timeout_hit = (wait_cnt_q == TmW'(TIMEOUT_CYCLES - 1));
    assign timeout     = timeout_q;

    // Wait counter runs only in WAIT_PRESS, so it restarts from zero on every entry
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == StWaitPress) ? wait_cnt_q + 1'b1 : '0;
            timeout_q  <= cap_timeout;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout            = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a falling request in WAIT_PRESS beats a simultaneous press or timeout
    always_comb begin
        state_d     = state_q;
        cap_press   = 1'b0;
        cap_timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_in) state_d = StArm;
            end
            StArm: begin
                if (!req_in) begin
                    state_d = StIdle;
                end else if (!btn_db_q) begin
                    state_d = StWaitPress;
                end
            end
            StWaitPress: begin
                if (!req_in) begin
                    state_d = StIdle;
                end else if (press_q) begin
                    state_d   = StDone;
                    cap_press = 1'b1;
                end else if (timeout_hit) begin
                    state_d     = StDone;
                    cap_timeout = 1'b1;
                end
            end
            StDone: begin
                state_d = StWaitReqLow;
            end
            StWaitReqLow: begin
                if (!req_in) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Captured word: switches on a press, zero on a timeout, otherwise held
    always_ff @(posedge clock) begin
        if (reset) begin
            dado_lido_q <= '0;
        end else if (cap_press) begin
            dado_lido_q <= DATA_W'(sw_s2_q);
        end else if (cap_timeout) begin
            dado_lido_q <= '0;
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        dado_lido   = dado_lido_q;
        dado_valido = (state_q == StDone);
        ocupado     = (state_q == StArm) || (state_q == StWaitPress);
        ledin       = (state_q == StArm) || (state_q == StWaitPress);
    end

endmodule

// File: tb/tb_io_entrada_responder.sv
// Self-checking bench for io_entrada_responder with DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=50.
module tb_io_entrada_responder;

    localparam int unsigned D   = 4;
    localparam int unsigned TMO = 50;
    // Press-to-valid latency: 2 sync + D debounce + 1 edge detect + 1 DONE register
    localparam int LAT = 2 + D + 2;

    logic        clock;
    logic        reset;
    logic        botaoIN;
    logic [3:0]  entradaDeDados;
    logic        req_in;
    logic [31:0] dado_lido;
    logic        dado_valido;
    logic        ocupado;
    logic        ledin;
    logic        timeout;

    int n_pass;
    int n_total;
    int valid_cnt;
    int timeout_cnt;
    logic [31:0] last_lido;
    logic [31:0] exp_q[$];

    io_entrada_responder #(
        .DEBOUNCE_CYCLES(D),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .botaoIN       (botaoIN),
        .entradaDeDados(entradaDeDados),
        .req_in        (req_in),
        .dado_lido     (dado_lido),
        .dado_valido   (dado_valido),
        .ocupado       (ocupado),
        .ledin         (ledin),
        .timeout       (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse counters sampled mid-cycle
    always @(negedge clock) begin
        if (dado_valido === 1'b1) valid_cnt++;
        if (timeout === 1'b1) timeout_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference rule: captured word is the switch value zero-extended to 32 bits
    function automatic logic [31:0] expected_word(input logic [3:0] sw);
        logic [31:0] w;
        w = 32'd0;
        w[3:0] = sw;
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        while (lat < budget) begin
            tick(1);
            lat++;
            if (dado_valido === 1'b1) return;
        end
        lat = -1;
    endtask

    task automatic settle();
        req_in  = 1'b0;
        botaoIN = 1'b0;
        tick(D + 8);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_in = 1'b1; botaoIN = 1'b1; entradaDeDados = 4'hF;
        tick(3);
        n_total++;
        if (dado_lido !== 32'd0) $display("FAIL rst_lido: got %h want 0", dado_lido);
        else n_pass++;
        n_total++;
        if (dado_valido !== 1'b0) $display("FAIL rst_valido: got %b want 0", dado_valido);
        else n_pass++;
        n_total++;
        if (ocupado !== 1'b0) $display("FAIL rst_ocupado: got %b want 0", ocupado);
        else n_pass++;
        n_total++;
        if (ledin !== 1'b0) $display("FAIL rst_ledin: got %b want 0", ledin);
        else n_pass++;
        n_total++;
        if (timeout !== 1'b0) $display("FAIL rst_timeout: got %b want 0", timeout);
        else n_pass++;
        reset = 1'b0;
        settle();
        last_lido = 32'd0;
    endtask

    task automatic test_basic();
        int v0, lat;
        req_in = 1'b1;
        tick(3);
        n_total++;
        if (ocupado !== 1'b1) $display("FAIL basic_busy: got %b want 1", ocupado);
        else n_pass++;
        n_total++;
        if (ledin !== 1'b1) $display("FAIL basic_led: got %b want 1", ledin);
        else n_pass++;
        v0 = valid_cnt;
        entradaDeDados = 4'h7;
        botaoIN = 1'b1;
        wait_valid(30, lat);
        n_total++;
        if (lat != LAT) $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
        else n_pass++;
        n_total++;
        if (dado_lido !== expected_word(4'h7)) $display("FAIL basic_lido: got %h want 7", dado_lido);
        else n_pass++;
        n_total++;
        if (ocupado !== 1'b0) $display("FAIL basic_busy_fall: got %b want 0", ocupado);
        else n_pass++;
        tick((lat > 0 && lat < 20) ? 20 - lat : 1);
        n_total++;
        if (valid_cnt - v0 != 1) $display("FAIL basic_pulses: got %0d want 1", valid_cnt - v0);
        else n_pass++;
        n_total++;
        if (ledin !== 1'b0) $display("FAIL basic_led_after: got %b want 0", ledin);
        else n_pass++;
        last_lido = expected_word(4'h7);
        settle();
    endtask

    task automatic test_bounce();
        int v0, lat, t, len;
        logic level;
        req_in = 1'b1;
        tick(3);
        v0 = valid_cnt;
        level = 1'b0;
        t = 0;
        while (t < 30) begin
            level = ~level;
            len = int'($urandom_range(1, 3));
            botaoIN = level;
            entradaDeDados = 4'($urandom_range(0, 15));
            tick(len);
            t += len;
        end
        botaoIN = 1'b0;
        tick(2);
        n_total++;
        if (valid_cnt != v0) $display("FAIL bounce_no_valid: got %0d want 0", valid_cnt - v0);
        else n_pass++;
        n_total++;
        if (dado_lido !== last_lido) $display("FAIL bounce_hold: got %h want %h", dado_lido, last_lido);
        else n_pass++;
        entradaDeDados = 4'h9;
        botaoIN = 1'b1;
        wait_valid(30, lat);
        n_total++;
        if (lat != LAT) $display("FAIL bounce_latency: got %0d want %0d", lat, LAT);
        else n_pass++;
        n_total++;
        if (dado_lido !== expected_word(4'h9)) $display("FAIL bounce_lido: got %h want 9", dado_lido);
        else n_pass++;
        tick(3);
        n_total++;
        if (valid_cnt - v0 != 1) $display("FAIL bounce_pulses: got %0d want 1", valid_cnt - v0);
        else n_pass++;
        last_lido = expected_word(4'h9);
        settle();
    endtask

    task automatic test_preheld();
        int v0, lat;
        entradaDeDados = 4'hC;
        botaoIN = 1'b1;
        tick(D + 6);
        req_in = 1'b1;
        v0 = valid_cnt;
        tick(20);
        n_total++;
        if (ocupado !== 1'b1) $display("FAIL preheld_busy: got %b want 1", ocupado);
        else n_pass++;
        n_total++;
        if (valid_cnt != v0) $display("FAIL preheld_no_valid: got %0d want 0", valid_cnt - v0);
        else n_pass++;
        n_total++;
        if (dado_lido !== last_lido) $display("FAIL preheld_hold: got %h want %h", dado_lido, last_lido);
        else n_pass++;
        botaoIN = 1'b0;
        tick(D + 6);
        entradaDeDados = 4'h3;
        botaoIN = 1'b1;
        wait_valid(30, lat);
        n_total++;
        if (dado_lido !== expected_word(4'h3)) $display("FAIL preheld_lido: got %h want 3", dado_lido);
        else n_pass++;
        last_lido = expected_word(4'h3);
        tick(5);
        botaoIN = 1'b0;
        tick(D + 6);
    endtask

    // Runs straight after test_preheld with the request still held high
    task automatic test_held_req();
        int v0, lat;
        v0 = valid_cnt;
        entradaDeDados = 4'hA;
        botaoIN = 1'b1;
        tick(D + 10);
        n_total++;
        if (valid_cnt != v0) $display("FAIL held_no_valid: got %0d want 0", valid_cnt - v0);
        else n_pass++;
        n_total++;
        if (dado_lido !== last_lido) $display("FAIL held_hold: got %h want %h", dado_lido, last_lido);
        else n_pass++;
        n_total++;
        if (ocupado !== 1'b0) $display("FAIL held_busy: got %b want 0", ocupado);
        else n_pass++;
        botaoIN = 1'b0;
        tick(D + 6);
        req_in = 1'b0;
        tick(2);
        req_in = 1'b1;
        tick(3);
        botaoIN = 1'b1;
        wait_valid(30, lat);
        n_total++;
        if (dado_lido !== expected_word(4'hA)) $display("FAIL held_lido: got %h want a", dado_lido);
        else n_pass++;
        last_lido = expected_word(4'hA);
        settle();
    endtask

    task automatic test_abort();
        int v0;
        req_in = 1'b1;
        tick(3);
        req_in = 1'b0;
        tick(1);
        n_total++;
        if (ocupado !== 1'b0) $display("FAIL abort_busy: got %b want 0", ocupado);
        else n_pass++;
        n_total++;
        if (ledin !== 1'b0) $display("FAIL abort_led: got %b want 0", ledin);
        else n_pass++;
        // Request drops on the very cycle the press pulse reaches the FSM
        v0 = valid_cnt;
        req_in = 1'b1;
        tick(3);
        entradaDeDados = 4'h6;
        botaoIN = 1'b1;
        tick(LAT - 1);
        n_total++;
        if (ocupado !== 1'b1) $display("FAIL abort_sim_busy: got %b want 1", ocupado);
        else n_pass++;
        req_in = 1'b0;
        tick(D + 6);
        n_total++;
        if (valid_cnt != v0) $display("FAIL abort_sim_valid: got %0d want 0", valid_cnt - v0);
        else n_pass++;
        n_total++;
        if (dado_lido !== last_lido) $display("FAIL abort_sim_lido: got %h want %h", dado_lido, last_lido);
        else n_pass++;
        settle();
        // Reset on the same cycle as the press
        req_in = 1'b1;
        tick(3);
        entradaDeDados = 4'h5;
        botaoIN = 1'b1;
        tick(LAT - 1);
        reset = 1'b1;
        tick(1);
        n_total++;
        if (dado_valido !== 1'b0) $display("FAIL abort_rst_valid: got %b want 0", dado_valido);
        else n_pass++;
        n_total++;
        if (ocupado !== 1'b0 || ledin !== 1'b0) $display("FAIL abort_rst_busy: got %b%b want 00", ocupado, ledin);
        else n_pass++;
        n_total++;
        if (dado_lido !== 32'd0) $display("FAIL abort_rst_lido: got %h want 0", dado_lido);
        else n_pass++;
        reset = 1'b0;
        last_lido = 32'd0;
        settle();
    endtask

    task automatic test_random();
        int lat;
        logic [3:0] sw;
        logic [31:0] want;
        for (int i = 0; i < 6; i++) begin
            sw = 4'($urandom_range(0, 15));
            exp_q.push_back(expected_word(sw));
            entradaDeDados = sw;
            req_in = 1'b1;
            tick(int'($urandom_range(3, 6)));
            botaoIN = 1'b1;
            wait_valid(30, lat);
            want = exp_q.pop_front();
            n_total++;
            if (lat != LAT) $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, LAT);
            else n_pass++;
            n_total++;
            if (dado_lido !== want) $display("FAIL rand_lido[%0d]: got %h want %h", i, dado_lido, want);
            else n_pass++;
            last_lido = want;
            settle();
        end
    endtask

    task automatic test_timeout();
        int v0, t0;
`ifdef IO_TIMEOUT_EN
        int lat;
        t0 = timeout_cnt;
        req_in = 1'b1;
        wait_valid(80, lat);
        n_total++;
        if (lat < TMO || lat > TMO + 3) $display("FAIL tmo_latency: got %0d want %0d..%0d", lat, TMO, TMO + 3);
        else n_pass++;
        n_total++;
        if (timeout !== 1'b1) $display("FAIL tmo_flag: got %b want 1", timeout);
        else n_pass++;
        n_total++;
        if (dado_lido !== 32'd0) $display("FAIL tmo_lido: got %h want 0", dado_lido);
        else n_pass++;
        tick(2);
        n_total++;
        if (timeout_cnt - t0 != 1) $display("FAIL tmo_pulses: got %0d want 1", timeout_cnt - t0);
        else n_pass++;
        last_lido = 32'd0;
`else
        v0 = valid_cnt;
        t0 = timeout_cnt;
        req_in = 1'b1;
        tick(200);
        n_total++;
        if (timeout_cnt != t0) $display("FAIL notmo_flag: got %0d want 0", timeout_cnt - t0);
        else n_pass++;
        n_total++;
        if (valid_cnt != v0) $display("FAIL notmo_valid: got %0d want 0", valid_cnt - v0);
        else n_pass++;
        n_total++;
        if (ocupado !== 1'b1) $display("FAIL notmo_busy: got %b want 1", ocupado);
        else n_pass++;
`endif
        settle();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        valid_cnt = 0;
        timeout_cnt = 0;
        last_lido = 32'd0;
        reset = 1'b1;
        req_in = 1'b0;
        botaoIN = 1'b0;
        entradaDeDados = 4'h0;
        test_reset();
        test_basic();
        test_bounce();
        test_preheld();
        test_held_req();
        test_abort();
        test_random();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
